// File: rtl/noc_pkg.sv
// Shared router constants: packet width, FIFO RAM address width and derived depth.
package noc_pkg;

    localparam int unsigned PACKET_WIDTH = 55;
    localparam int unsigned ADDR_WIDTH   = 4;
    localparam int unsigned FIFO_DEPTH   = 1 << ADDR_WIDTH;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Pointer/counter unit of the RAM-backed FIFO: write/read pointers, RAM occupancy
// and the push/fetch handshake decisions. Exposes the next occupancy when
// NOC_FIFO_ALMOST_FULL_EN is defined so the top can register almost_full.
module ram_fifo_ptr
    import noc_pkg::*;
#(
    parameter int unsigned addressWidth = ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    input  logic                    outValid,
    input  logic                    outReady,
    output logic                    inReady,
    output logic                    push,
    output logic                    fetch,
    output logic [addressWidth-1:0] wrPtr,
    output logic [addressWidth-1:0] rdPtr,
`ifdef NOC_FIFO_ALMOST_FULL_EN
    output logic [addressWidth:0]   nextCnt,
`endif
    output logic [addressWidth:0]   ramCnt
);

    localparam int unsigned CNT_WIDTH = addressWidth + 1;
    localparam int unsigned DEPTH     = 1 << addressWidth;

    logic [addressWidth:0] cntNext;

    // Handshake decisions depend on registered state only (no out_ready -> in_ready path).
    always_comb begin
        inReady = !reset && (ramCnt < CNT_WIDTH'(DEPTH));
        push    = inValid && inReady;
        fetch   = !reset && (ramCnt != '0) && (!outValid || outReady);
        cntNext = ramCnt + CNT_WIDTH'(push) - CNT_WIDTH'(fetch);
    end

`ifdef NOC_FIFO_ALMOST_FULL_EN
    assign nextCnt = cntNext;
`endif

    // Pointers wrap naturally at DEPTH; occupancy tracks RAM slots only, not the head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            ramCnt <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + addressWidth'(1);
            end
            if (fetch) begin
                rdPtr <= rdPtr + addressWidth'(1);
            end
            ramCnt <= cntNext;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port packet RAM.
// The RAM's registered read output is the FIFO head; capacity is DEPTH+1.
// Optional feature: define NOC_FIFO_ALMOST_FULL_EN to add almostFullThr / almost_full.
module ram_fifo_ctrl
    import noc_pkg::*;
#(
    parameter int unsigned packetwidth  = PACKET_WIDTH,
    parameter int unsigned addressWidth = ADDR_WIDTH
`ifdef NOC_FIFO_ALMOST_FULL_EN
    ,
    parameter int unsigned almostFullThr = (1 << addressWidth) - 2
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [packetwidth-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [packetwidth-1:0]  out_data,
    input  logic                    out_ready,
    output logic [addressWidth:0]   fill_level,
    output logic                    ram_we,
    output logic [addressWidth-1:0] ram_waddr,
    output logic [packetwidth-1:0]  ram_wdata,
    output logic                    ram_re,
    output logic [addressWidth-1:0] ram_raddr,
`ifdef NOC_FIFO_ALMOST_FULL_EN
    output logic                    almost_full,
`endif
    input  logic [packetwidth-1:0]  ram_rdata
);

    localparam int unsigned CNT_WIDTH = addressWidth + 1;

    logic                    push;
    logic                    fetch;
    logic                    pop;
    logic [addressWidth-1:0] wrPtr;
    logic [addressWidth-1:0] rdPtr;
    logic [addressWidth:0]   ramCnt;
`ifdef NOC_FIFO_ALMOST_FULL_EN
    logic [addressWidth:0]   nextCnt;
`endif

    ram_fifo_ptr #(
        .addressWidth(addressWidth)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .inValid  (in_valid),
        .outValid (out_valid),
        .outReady (out_ready),
        .inReady  (in_ready),
        .push     (push),
        .fetch    (fetch),
        .wrPtr    (wrPtr),
        .rdPtr    (rdPtr),
`ifdef NOC_FIFO_ALMOST_FULL_EN
        .nextCnt  (nextCnt),
`endif
        .ramCnt   (ramCnt)
    );

    // RAM port mapping and head/occupancy view.
    always_comb begin
        pop        = out_valid && out_ready;
        ram_we     = push;
        ram_waddr  = wrPtr;
        ram_wdata  = in_data;
        ram_re     = fetch;
        ram_raddr  = rdPtr;
        out_data   = ram_rdata;
        fill_level = ramCnt + CNT_WIDTH'(out_valid);
    end

    // Head valid: a fetch loads the RAM output register; a pop without refill empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (fetch) begin
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOC_FIFO_ALMOST_FULL_EN
    // Registered from next occupancy so it lines up with the RAM count it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (nextCnt >= CNT_WIDTH'(almostFullThr));
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural dual-port RAM and a data scoreboard.
module tb_ram_fifo_ctrl;

    localparam int unsigned PW = 55;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   fill_level;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [PW-1:0] ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [PW-1:0] ram_rdata;
`ifdef NOC_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] sb[$];
    logic [PW-1:0] mem[1<<AW];
    int  lastW = -1;
    int  lastR = -1;
    bit  wrapW = 0;
    bit  wrapR = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .packetwidth  (PW),
        .addressWidth (AW)
`ifdef NOC_FIFO_ALMOST_FULL_EN
        ,
        .almostFullThr(14)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_re     (ram_re),
        .ram_raddr  (ram_raddr),
`ifdef NOC_FIFO_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .ram_rdata  (ram_rdata)
    );

    // Behavioural RAM: registered read output held when ram_re is low.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    // Scoreboard: record accepted packets, compare every popped head in order.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_order: popped %h with nothing expected", out_data);
                end else begin
                    logic [PW-1:0] exp;
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL pop_order: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            if (ram_we) begin
                if (lastW == 15 && ram_waddr == 0) wrapW = 1;
                lastW = int'(ram_waddr);
            end
            if (ram_re) begin
                if (lastR == 15 && ram_raddr == 0) wrapR = 1;
                lastR = int'(ram_raddr);
            end
        end
    end

    function automatic logic [PW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[PW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (out_valid === 1'b0 && fill_level === '0) done = 1;
            else step();
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (!done || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: done=%0d left=%0d required done=1 left=0", name, done, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b fill=%0d in_ready=%b required 0/0/0", out_valid, fill_level, in_ready);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = PW'(12'h0AB);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== '0) begin
            errors++;
            $display("FAIL single_write: ram_we=%b waddr=%0d required 1/0", ram_we, ram_waddr);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ram_re !== 1'b1) begin
            errors++;
            $display("FAIL single_t1: out_valid=%b ram_re=%b required 0/1", out_valid, ram_re);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== PW'(12'h0AB) || fill_level !== 5'd1) begin
            errors++;
            $display("FAIL single_t2: out_valid=%b data=%h fill=%0d required 1/0ab/1", out_valid, out_data, fill_level);
        end
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0) begin
            errors++;
            $display("FAIL single_pop: out_valid=%b fill=%0d required 0/0", out_valid, fill_level);
        end
        step();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = rnd();
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_accept%0d: in_ready=%b required 1", i, in_ready);
            end
            step();
        end
        in_data = PW'(16'h0BAD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || ram_we !== 1'b0 || fill_level !== 5'd17) begin
                errors++;
                $display("FAIL fill_full: in_ready=%b ram_we=%b fill=%0d required 0/0/17", in_ready, ram_we, fill_level);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        wrapW = 0; wrapR = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = rnd();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid%0d: out_valid=%b required 1", i, out_valid);
            end
            step();
        end
        drain("stream");
        checks++;
        if (!wrapW || !wrapR) begin
            errors++;
            $display("FAIL ptr_wrap: wrapW=%0d wrapR=%0d required 1/1", wrapW, wrapR);
        end
    endtask

    task automatic test_stall();
        logic [PW-1:0] held;
        bit seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = rnd();
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
            step();
        end
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (!seen || out_valid !== 1'b1 || out_data !== held || ram_re !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: valid=%b data=%h re=%b required 1/%h/0", i, out_valid, out_data, ram_re, held);
            end
            step();
        end
        drain("stall");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = rnd();
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b fill=%0d in_ready=%b required 0/0/1", out_valid, fill_level, in_ready);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rnd();
            step();
        end
        drain("refill");
    endtask

`ifdef NOC_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        int expCnt;
        out_ready = 1'b0;
        for (int n = 0; n <= 16; n++) begin
            in_valid = (n < 16); in_data = rnd();
            expCnt = (n <= 1) ? n : n - 1;
            @(negedge clk);
            checks++;
            if (almost_full !== (expCnt >= 14)) begin
                errors++;
                $display("FAIL af_rise%0d: almost_full=%b required %b", n, almost_full, expCnt >= 14);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j <= 15; j++) begin
            expCnt = 15 - j;
            @(negedge clk);
            checks++;
            if (almost_full !== (expCnt >= 14)) begin
                errors++;
                $display("FAIL af_fall%0d: almost_full=%b required %b", j, almost_full, expCnt >= 14);
            end
            step();
        end
        drain("af");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef NOC_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
